// File: rtl/half_tone4.sv
// half_tone4: ramped burst tone generator emitting four signed samples per clock
module half_tone4 #(
  parameter int NBITS = 12,
  parameter int PHASE_BITS = 24,
  parameter int LUT_BITS = 10,
  parameter int RAMP_STEP = 8,
  localparam int NSAMP = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [PHASE_BITS-1:0]    freq_i,
  input  logic [15:0]              burst_len_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  output logic [NBITS*NSAMP-1:0]   dat_o,
  output logic                     busy_o,
  output logic                     done_o
);
  typedef enum logic [1:0] {IDLE, RAMP_UP, ON, RAMP_DOWN} state_t;
  localparam real PI = 3.14159265358979323846;
  localparam real AMP = real'(2 ** (NBITS - 1) - 1);
  localparam logic signed [NBITS+9:0] RND = 128;
  state_t state, state_n;
  logic [PHASE_BITS-1:0] acc, freq_r;
  logic [15:0] blen_r, cnt;
  logic [8:0] gain, gain_up, gain_dn, g1, g2;
  logic go, done_q;
  logic signed [NBITS-1:0] lut [2**LUT_BITS];
  for (genvar a = 0; a < 2**LUT_BITS; a++) begin : g_lut
    localparam real V = AMP * $sin(2.0 * PI * a / real'(2**LUT_BITS));
    assign lut[a] = NBITS'($rtoi(V < 0.0 ? V - 0.5 : V + 0.5));
  end
  assign go = start_i && !stop_i;
  assign gain_up = gain + 9'(RAMP_STEP);
  assign gain_dn = gain > 9'(RAMP_STEP) ? gain - 9'(RAMP_STEP) : '0;
  // state register
  always_ff @(posedge clk_i)
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  // next-state: ramp in, hold for the burst length or until stopped, ramp out
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? RAMP_UP : IDLE;
      RAMP_UP: state_n = stop_i ? RAMP_DOWN : gain_up >= 9'd256 ? ON : RAMP_UP;
      ON:      state_n = stop_i || (blen_r != '0 && cnt == blen_r - 16'd1) ? RAMP_DOWN : ON;
      default: state_n = gain_dn == '0 ? IDLE : RAMP_DOWN;
    endcase
  end
  // status outputs decoded straight from the state register
  always_comb begin
    busy_o = state != IDLE;
    cfg_ready_o = state == IDLE;
    done_o = done_q;
  end
  // config capture, phase accumulator, gain envelope and ON-length counter
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      freq_r <= '0;
      blen_r <= '0;
      acc <= '0;
      gain <= '0;
      cnt <= '0;
      done_q <= 1'b0;
      g1 <= '0;
      g2 <= '0;
    end else begin
      if (cfg_valid_i && state == IDLE) begin
        freq_r <= freq_i;
        blen_r <= burst_len_i;
      end
      acc <= state == IDLE ? (go ? '0 : acc) : acc + (freq_r << 2);
      gain <= state == RAMP_UP ? (stop_i ? gain : gain_up) :
              state == RAMP_DOWN ? gain_dn : state == ON ? gain : '0;
      cnt <= state == ON ? cnt + 16'd1 : '0;
      done_q <= state == RAMP_DOWN && state_n == IDLE;
      g1 <= gain;
      g2 <= g1;
    end
  for (genvar k = 0; k < NSAMP; k++) begin : g_s
    logic [LUT_BITS-1:0] addr;
    logic signed [NBITS-1:0] lq, dq;
    logic signed [NBITS+9:0] pr;
    assign pr = (NBITS+10)'(lq) * (NBITS+10)'($signed({1'b0, g2})) + RND;
    assign dat_o[NBITS*k +: NBITS] = dq;
    // phase add -> table read -> gain multiply with rounding
    always_ff @(posedge clk_i)
      if (!rst_ni) begin
        addr <= '0;
        lq <= '0;
        dq <= '0;
      end else begin
        addr <= LUT_BITS'((acc + PHASE_BITS'(k) * freq_r) >> (PHASE_BITS - LUT_BITS));
        lq <= lut[addr];
        dq <= NBITS'(pr >>> 8);
      end
  end
endmodule

// File: tb/tb_half_tone4.sv
// tb_half_tone4: scoreboard plus timing-table bench for half_tone4
module tb_half_tone4;
  localparam real PI = 3.14159265358979323846;
  localparam int RS = 8;
  logic clk_i = 1'b0, rst_ni = 1'b0, cfg_valid_i = 1'b0, start_i = 1'b0, stop_i = 1'b0;
  logic [23:0] freq_i = '0;
  logic [15:0] burst_len_i = '0;
  logic cfg_ready_o, busy_o, done_o;
  logic [47:0] dat_o;

  half_tone4 dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .freq_i(freq_i), .burst_len_i(burst_len_i), .start_i(start_i), .stop_i(stop_i),
    .dat_o(dat_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int tests = 0, fails = 0, cyc = 0;
  int sin_tab [1024];
  int m_st = 0, m_gain = 0, m_blen = 0, m_cnt = 0;
  logic [23:0] m_acc = '0, m_freq = '0;
  bit m_done = 1'b0;
  logic [47:0] sb [$];

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [47:0] exp_word(logic [23:0] acc, logic [23:0] f, int g);
    logic [47:0] w;
    logic [23:0] ph;
    int y;
    for (int k = 0; k < 4; k++) begin
      ph = acc + 24'(k) * f;
      y = (sin_tab[int'(ph[23:14])] * g + 128) >>> 8;
      w[12*k +: 12] = 12'(y);
    end
    return w;
  endfunction

  initial
    for (int a = 0; a < 1024; a++) begin
      real x;
      x = 2047.0 * $sin(2.0 * PI * a / 1024.0);
      sin_tab[a] = $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
    end

  // behavioural reference: advances on each rising edge, expected words queued
  initial forever begin
    @(posedge clk_i);
    cyc++;
    m_done = 1'b0;
    if (!rst_ni) begin
      m_st = 0; m_acc = '0; m_gain = 0; m_freq = '0; m_blen = 0; m_cnt = 0;
      sb.delete();
      repeat (3) sb.push_back('0);
    end else begin
      case (m_st)
        0: begin
          if (cfg_valid_i) begin m_freq = freq_i; m_blen = int'(burst_len_i); end
          if (start_i && !stop_i) begin m_st = 1; m_acc = '0; m_gain = 0; end
        end
        1: begin
          m_acc = m_acc + 24'(4 * m_freq);
          if (stop_i) m_st = 3;
          else begin
            m_gain = m_gain + RS;
            if (m_gain == 256) begin m_st = 2; m_cnt = 0; end
          end
        end
        2: begin
          m_acc = m_acc + 24'(4 * m_freq);
          if (stop_i || (m_blen != 0 && m_cnt == m_blen - 1)) m_st = 3;
          m_cnt++;
        end
        default: begin
          m_acc = m_acc + 24'(4 * m_freq);
          m_gain = m_gain - RS;
          if (m_gain == 0) begin m_st = 0; m_done = 1'b1; end
        end
      endcase
    end
    sb.push_back(exp_word(m_acc, m_freq, m_gain));
  end

  // scoreboard compare, three clocks behind the reference
  initial forever begin
    @(negedge clk_i);
    if (sb.size() == 4) chk("sb_dat", dat_o, sb.pop_front());
    if (cyc > 0) begin
      chk("sb_busy", busy_o, m_st != 0);
      chk("sb_ready", cfg_ready_o, m_st == 0);
      chk("sb_done", done_o, m_done);
    end
  end

  typedef struct {
    logic [23:0] freq;
    logic [15:0] blen;
    int stop_at;
    int exp_done;
    int exp_full;
    bit ramp;
  } vec_t;
  vec_t v [7];
  localparam logic [47:0] FS4 = 48'h801_000_7FF_000;

  task automatic start_burst(logic [23:0] f, logic [15:0] l, output int n0);
    @(negedge clk_i);
    cfg_valid_i = 1'b1; freq_i = f; burst_len_i = l; start_i = 1'b1;
    n0 = cyc;
    @(negedge clk_i);
    cfg_valid_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic wait_done(string name);
    for (int c = 0; c < 100 && !done_o; c++) @(negedge clk_i);
    chk(name, done_o, 1);
  endtask

  initial begin
    int n0, done_k, full_k, k, s1;
    v[0] = '{24'h400000, 16'd0,   200, 233, 36, 1'b1};
    v[1] = '{24'h400000, 16'd100, 0,   165, 36, 1'b1};
    v[2] = '{24'h800000, 16'd0,   11,  22,  -1, 1'b0};
    v[3] = '{24'h400000, 16'd1,   0,   66,  36, 1'b1};
    v[4] = '{24'h400000, 16'd0,   2,   4,   -1, 1'b0};
    v[5] = '{24'h123456, 16'd10,  0,   75,  -2, 1'b0};
    v[6] = '{24'h400000, 16'd10,  50,  75,  36, 1'b1};
    repeat (2) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", cfg_ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_dat", dat_o, 0);
    rst_ni = 1'b1;
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < 50 && busy_o; c++) @(negedge clk_i);
      chk("idle_before", busy_o, 0);
      start_burst(v[i].freq, v[i].blen, n0);
      done_k = -1; full_k = -1;
      for (int c = 0; c < 400 && done_k < 0; c++) begin
        k = cyc - n0;
        s1 = int'($signed(dat_o[23:12]));
        if (v[i].ramp && k >= 4 && k <= 36) chk("ramp_s1", s1, (2047 * 8 * (k - 4) + 128) >>> 8);
        if (full_k < 0 && s1 == 2047) full_k = k;
        if (done_o) done_k = k;
        stop_i = v[i].stop_at > 0 && k == v[i].stop_at;
        if (done_k < 0) @(negedge clk_i);
      end
      stop_i = 1'b0;
      chk("done_time", done_k, v[i].exp_done);
      if (v[i].exp_full != -2) chk("full_time", full_k, v[i].exp_full);
      repeat (3) @(negedge clk_i);
      chk("tail_zero", dat_o, 0);
    end
    @(negedge clk_i);
    start_i = 1'b1; stop_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; stop_i = 1'b0;
    @(negedge clk_i);
    chk("start_stop_idle", busy_o, 0);
    start_burst(24'h400000, 16'd0, n0);
    repeat (49) @(negedge clk_i);
    chk("on_ready", cfg_ready_o, 0);
    chk("on_pattern", dat_o, FS4);
    cfg_valid_i = 1'b1; freq_i = 24'h800000; start_i = 1'b1;
    @(negedge clk_i);
    cfg_valid_i = 1'b0; start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("cfg_ignored", dat_o, FS4);
    chk("start_ignored", busy_o, 1);
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    wait_done("stop_done");
    start_burst(24'h123457, 16'd0, n0);
    repeat (60) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_dat", dat_o, 0);
    chk("midrst_ready", cfg_ready_o, 1);
    rst_ni = 1'b1;
    start_burst(24'h100000, 16'd0, n0);
    repeat (35) @(negedge clk_i);
    chk("restart_w0", dat_o, 48'h763_5A7_30F_000);
    @(negedge clk_i);
    chk("restart_w1", dat_o, 48'h30F_5A7_763_7FF);
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    wait_done("restart_done");
    repeat (4) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/half_tone4.md
# half_tone4

Programmable burst tone generator producing NSAMP=4 parallel signed samples per clock. It is the stimulus source for the halfband notch path: it emits a tone that ramps in, holds and ramps out, on the same 4-sample bus format the notch filters consume. Typical use is a tone at fs/4, the notch centre, injected ahead of the filter chain for in-system rejection checks. It sits between the ADC data mux and the filter bank.

## Interface
- NBITS, 12, sample width (signed, two's complement)
- NSAMP, 4, localparam; samples per clock
- PHASE_BITS, 24, phase accumulator width
- LUT_BITS, 10, full-wave sine table address width
- RAMP_STEP, 8, gain increment/decrement per clock; must be a power of two ≤ 256

Ports:
- clk_i  in  1  sample-bus clock
- rst_ni  in  1  reset; **one clock; reset is synchronous and active-low**
- cfg_valid_i  in  1  config offer
- cfg_ready_o  out  1  high only in IDLE
- freq_i  in  PHASE_BITS  phase increment per sample, captured on cfg handshake
- burst_len_i  in  16  ON-state length in clocks, captured on cfg handshake; 0 = continuous
- start_i  in  1  start pulse
- stop_i  in  1  stop request
- dat_o  out  NBITS*NSAMP  sample k at [NBITS*k +: NBITS]; k=0 earliest in time
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-clock pulse on RAMP_DOWN→IDLE

## Operation
- States: IDLE, RAMP_UP, ON, RAMP_DOWN. Registers: acc (PHASE_BITS), gain (9 bits, 0..256, where 256 = unity), freq_r, blen_r, cnt (16).
- IDLE: cfg_ready_o=1. cfg_valid_i&cfg_ready_o loads freq_r and blen_r. Start conditions: start_i=1 and stop_i=0. On start: state→RAMP_UP, acc←0, gain←0. start_i and stop_i together in IDLE: stay in IDLE. start_i together with a cfg handshake: new config is loaded and the burst starts with it.
- RAMP_UP: each clock gain←gain+RAMP_STEP. The update that reaches 256 also sets state→ON and cnt←0. stop_i→RAMP_DOWN on the same edge; gain is not incremented on that edge.
- ON: gain=256; cnt increments each clock. If blen_r≠0 and cnt==blen_r−1, state→RAMP_DOWN. stop_i→RAMP_DOWN.
- RAMP_DOWN: each clock gain←gain−RAMP_STEP. The update that reaches 0 sets state→IDLE and pulses done_o. stop_i and start_i are ignored.
- start_i outside IDLE: ignored. cfg_valid_i outside IDLE: not accepted.
- Phase: acc advances by 4·freq_r each clock (mod 2^PHASE_BITS) in every non-IDLE state. Sample k phase = acc + k·freq_r. Address = top LUT_BITS bits of the phase (truncated).
- LUT: entry a = round(sin(2πa/2^LUT_BITS)·(2^(NBITS−1)−1)). Values are signed NBITS with range ±2047.
- Scaling: y = (lut·gain + 128) >>> 8 (arithmetic shift). The product is NBITS+10 signed bits. |y| ≤ 2047, so saturation is never needed.
- In IDLE, gain=0, so dat_o settles to 0.

## Timing
- Reset: state=IDLE, acc=0, gain=0, freq_r=0, blen_r=0, cnt=0, all pipeline registers 0. Therefore dat_o=0, busy_o=0, done_o=0, cfg_ready_o=1 from the first edge after reset is sampled.
- Reset asserted mid-burst: the same clear takes effect immediately, with no ramp-down.
- Pipeline: three register stages (phase add, LUT read, multiply/round). dat_o at edge t+3 reflects acc/gain/freq_r at edge t.
- busy_o and cfg_ready_o are registered from state (0 cycles behind state).
- done_o asserts on the edge state returns to IDLE. The last non-zero sample leaves dat_o up to 3 clocks later.
- start at edge N: state=RAMP_UP at N+1. State=ON at N+1+256/RAMP_STEP (N+33 with defaults). With blen_r=L, RAMP_DOWN begins at N+33+L and IDLE is reached at N+65+L.

## Test plan
- Reset, then cfg freq=0x400000 (fs/4), blen=0, start → ON-state dat_o samples repeat {0, +2047, 0, −2047} every clock; busy_o=1.
- Same config: check ramp. Gain at RAMP_UP clock j is 8j, and sample 1 at output = (2047·8j+128)>>>8, delayed 3 clocks. State=ON exactly 33 clocks after start.
- blen=100, freq=0x400000, start → RAMP_DOWN after 100 ON clocks. done_o pulses once at start+165 (that is, N+65+100). dat_o=0 from done_o+3 onwards.
- freq=0x800000 (fs/2) → all samples 0 at every gain. Then stop_i at RAMP_UP clock 10 → gain falls from 80 to 0 in 10 clocks, with no ON state.
- start_i and stop_i both high in IDLE → busy_o stays 0. cfg_valid_i during ON → cfg_ready_o=0 and freq_r unchanged.
- rst_ni low for 1 clock mid-ON → next edge: busy_o=0, dat_o=0, cfg_ready_o=1. Restart with a new freq and confirm acc restarts from 0.
